// File: rtl/uart_frame_dispatch.sv
// uart_frame_dispatch: frame hunter behind a UART receiver.
// Frame layout: SYNC, ADDR, LEN, LEN payload bytes, CSUM. The checksum is good when
// ADDR + LEN + payload + CSUM == 0 (mod 256). Payload is forwarded cut-through to
// destination ADDR through a one-entry output register; frames with an illegal
// address are consumed but not forwarded.
// Handshakes: a byte moves on a port only in a cycle where both valid and ready are
// high (rx_valid & rx_ready, dst_valid[k] & dst_ready[k]). A producer holds valid and
// data stable until the transfer happens; ready may change freely.
module uart_frame_dispatch #(
    parameter int          N_DEST      = 4,
    parameter logic [7:0]  SYNC        = 8'hA5,
    parameter int          TIMEOUT_CYC = 8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        dst_data,
    output logic [N_DEST-1:0] dst_valid,
    input  logic [N_DEST-1:0] dst_ready,
    output logic              dst_last,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int         SEL_W    = (N_DEST > 1) ? $clog2(N_DEST) : 1;
    localparam int         TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] N_DEST_B = 8'(N_DEST);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_DISCARD, S_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sel_q, sel_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               out_full_q, out_full_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [7:0]         dst_data_q, dst_data_d;
    logic               dst_last_q, dst_last_d;
    logic               frame_ok_q, frame_ok_d;
    logic               frame_err_q, frame_err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic accept;
    logic drain;
    logic stall;
    logic sel_legal;
    logic tmo_hit;

    // Handshake terms. The output register keeps its own destination so a byte
    // left over from an aborted frame still drains to the right consumer.
    always_comb begin
        drain     = out_full_q & dst_ready[out_sel_q];
        stall     = out_full_q & ~dst_ready[out_sel_q];
        rx_ready  = (state_q == S_PAYLOAD) ? ~stall : 1'b1;
        accept    = rx_valid & rx_ready;
        sel_legal = (sel_q < N_DEST_B);
        tmo_hit   = (state_q != S_IDLE) && !accept && !stall &&
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Next-state, datapath and status logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        out_full_d  = out_full_q;
        out_sel_d   = out_sel_q;
        dst_data_d  = dst_data_q;
        dst_last_d  = dst_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        if (drain) begin
            out_full_d = 1'b0;
            dst_last_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC) state_d = S_ADDR;
                end
                S_ADDR: begin
                    sel_d   = rx_data;
                    sum_d   = rx_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d = rx_data;
                    sum_d = sum_q + rx_data;
                    if (rx_data == 8'h00) state_d = S_CSUM;
                    else if (sel_legal)   state_d = S_PAYLOAD;
                    else                  state_d = S_DISCARD;
                end
                S_PAYLOAD: begin
                    out_full_d = 1'b1;
                    out_sel_d  = sel_q[SEL_W-1:0];
                    dst_data_d = rx_data;
                    dst_last_d = (cnt_q == 8'd1);
                    sum_d      = sum_q + rx_data;
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_CSUM;
                end
                S_DISCARD: begin
                    sum_d = sum_q + rx_data;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    // An illegal address outranks a checksum failure.
                    if (!sel_legal) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                    end else if (8'(sum_q + rx_data) == 8'h00) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = S_IDLE;
        end
    end

    // Inter-byte timer: cleared by every accept and while idle, frozen while the
    // payload path is back-pressured so a slow consumer never times a frame out.
    always_comb begin
        tmo_d = tmo_q;
        if (accept || (state_q == S_IDLE) || tmo_hit) tmo_d = '0;
        else if (!stall)                              tmo_d = tmo_q + TMO_W'(1);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            out_full_q  <= 1'b0;
            out_sel_q   <= '0;
            dst_data_q  <= '0;
            dst_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            out_full_q  <= out_full_d;
            out_sel_q   <= out_sel_d;
            dst_data_q  <= dst_data_d;
            dst_last_q  <= dst_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Output decode: the one-hot valid follows the output register's destination.
    always_comb begin
        dst_valid = '0;
        if (out_full_q) dst_valid[out_sel_q] = 1'b1;
        dst_data  = dst_data_q;
        dst_last  = dst_last_q;
        frame_ok  = frame_ok_q;
        frame_err = frame_err_q;
        err_code  = err_code_q;
    end

endmodule

// File: tb/tb_uart_frame_dispatch.sv
// Bench for uart_frame_dispatch: directed frames, a frame-level expectation model
// and a per-cycle compare process over payload and status outputs.
module tb_uart_frame_dispatch;

    localparam int         N_DEST = 4;
    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         TMO    = 16;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        dst_data;
    logic [N_DEST-1:0] dst_valid;
    logic [N_DEST-1:0] dst_ready;
    logic              dst_last;
    logic              frame_ok;
    logic              frame_err;
    logic [1:0]        err_code;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected payload entries {dest[3:0], last, data[7:0]} and frame statuses (0 = ok).
    logic [12:0] exp_q[$];
    logic [1:0]  st_q[$];

    logic [1:0]  last_err;
    int          n_deliv;
    logic [7:0]  last_data;
    int          last_dest;
    logic        last_flag;
    logic [7:0]  pay_buf[0:15];
    int          stall_cycles;
    int          obs_dest;
    logic [12:0] obs_e;
    logic [1:0]  obs_s;

    uart_frame_dispatch #(
        .N_DEST      (N_DEST),
        .SYNC        (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst_last  (dst_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Compare process: every payload transfer and every status pulse against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (dst_valid != '0) begin
                check("dst_valid_onehot", 32'($onehot(dst_valid)), 32'd1);
                if ((dst_valid & dst_ready) != '0) begin
                    obs_dest = 0;
                    for (int k = 0; k < N_DEST; k++) if (dst_valid[k]) obs_dest = k;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_payload_byte");
                    end else begin
                        obs_e = exp_q.pop_front();
                        check("dst_byte", {19'b0, 4'(obs_dest), dst_last, dst_data}, {19'b0, obs_e});
                    end
                    n_deliv++;
                    last_data = dst_data;
                    last_dest = obs_dest;
                    last_flag = dst_last;
                end
            end
            if (frame_ok || frame_err) begin
                check("pulse_exclusive", 32'(frame_ok & frame_err), 32'd0);
                if (st_q.size() == 0) begin
                    fail_now("unexpected_status_pulse");
                end else begin
                    obs_s = st_q.pop_front();
                    check("frame_status", frame_err ? {29'b0, 1'b1, err_code} : 32'd0,
                          (obs_s == 2'd0) ? 32'd0 : {29'b0, 1'b1, obs_s});
                    if (frame_ok) check("err_code_held", 32'(err_code), 32'(last_err));
                    if (obs_s != 2'd0) last_err = obs_s;
                end
            end
        end
    end

    // Driver: offer one byte, return one cycle after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic acc;
        waited   = 0;
        acc      = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        stall_cycles += waited;
        if (!acc) fail_now("send_byte_no_accept");
        rx_valid = 1'b0;
    endtask

    // Frame-level model: decides routing and status from the frame contents alone,
    // and is pinned against a hand-computed status for each vector.
    task automatic send_frame(input logic [7:0] addr, input int len, input logic [7:0] csum,
                              input logic [1:0] exp_st);
        logic [7:0] sum;
        logic [1:0] st;
        sum = addr + 8'(len);
        for (int i = 0; i < len; i++) sum = sum + pay_buf[i];
        if (addr >= 8'(N_DEST))       st = 2'd1;
        else if (8'(sum + csum) == 0) st = 2'd0;
        else                          st = 2'd2;
        check("model_pin", 32'(st), 32'(exp_st));
        if (addr < 8'(N_DEST))
            for (int i = 0; i < len; i++) exp_q.push_back({addr[3:0], (i == len - 1), pay_buf[i]});
        st_q.push_back(st);
        send_byte(SYNC);
        send_byte(addr);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) send_byte(pay_buf[i]);
        send_byte(csum);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            fail_now("drain_wait_expired");
            exp_q.delete();
            st_q.delete();
        end
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   d0;
        int   s0;
        int   cyc;
        logic seen;
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        dst_ready    = '1;
        last_err     = 2'd0;
        n_deliv      = 0;
        last_data    = 8'h00;
        last_dest    = 0;
        last_flag    = 1'b0;
        stall_cycles = 0;

        // Reset state
        @(posedge clk);
        #2;
        check("rst_dst_valid", 32'(dst_valid), 32'd0);
        check("rst_pulses", {30'b0, frame_ok, frame_err}, 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Good frame to dest 1, full throughput
        pay_buf[0] = 8'h10; pay_buf[1] = 8'h20; pay_buf[2] = 8'h30;
        d0 = n_deliv;
        s0 = stall_cycles;
        send_frame(8'h01, 3, 8'h9C, 2'd0);
        check("t1_no_stall", 32'(stall_cycles - s0), 32'd0);
        wait_done(100);
        check("t1_count", 32'(n_deliv - d0), 32'd3);
        check("t1_last", {23'b0, last_flag, last_data}, {23'b0, 1'b1, 8'h30});
        check("t1_dest", 32'(last_dest), 32'd1);

        // Same frame, bad checksum
        d0 = n_deliv;
        send_frame(8'h01, 3, 8'h9D, 2'd2);
        wait_done(100);
        check("t2_count", 32'(n_deliv - d0), 32'd3);
        check("t2_err_code", 32'(err_code), 32'd2);

        // Illegal address: consumed, nothing forwarded
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22;
        d0 = n_deliv;
        send_frame(8'h07, 2, 8'hD0, 2'd1);
        wait_done(100);
        check("t3_no_payload", 32'(n_deliv - d0), 32'd0);
        check("t3_err_code", 32'(err_code), 32'd1);

        // Junk before SYNC, SYNC value as payload data
        send_byte(8'h00);
        send_byte(8'hFF);
        pay_buf[0] = 8'hA5; pay_buf[1] = 8'hA5;
        send_frame(8'h03, 2, 8'hB1, 2'd0);
        wait_done(100);
        check("t4_last_dest", 32'(last_dest), 32'd3);

        // Inter-byte timeout after a partial frame
        exp_q.push_back({4'd0, 1'b0, 8'h55});
        st_q.push_back(2'd3);
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h55);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3 * TMO) begin
            @(negedge clk);
            if (frame_err) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("t5_timeout_seen", 32'(seen), 32'd1);
        check("t5_timeout_window", 32'(cyc >= TMO - 1 && cyc <= TMO + 1), 32'd1);
        @(posedge clk);
        #1;
        check("t5_err_code", 32'(err_code), 32'd3);
        wait_done(100);
        send_frame(8'h00, 0, 8'h00, 2'd0);
        wait_done(100);

        // Back-pressure longer than the timeout: no timeout, bytes held
        pay_buf[0] = 8'h77; pay_buf[1] = 8'h88; pay_buf[2] = 8'h99;
        d0 = n_deliv;
        dst_ready = 4'b1011;
        fork
            send_frame(8'h02, 3, 8'h63, 2'd0);
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("t6_rx_ready_low", 32'(rx_ready), 32'd0);
                check("t6_valid_held", {20'b0, 4'(dst_valid), dst_data}, {20'b0, 4'b0100, 8'h77});
                repeat (2 * TMO) @(posedge clk);
                @(negedge clk);
                check("t6_still_stalled", 32'(rx_ready), 32'd0);
                @(posedge clk);
                #1;
                dst_ready = '1;
            end
        join
        wait_done(100);
        check("t6_count", 32'(n_deliv - d0), 32'd3);

        // Reset in the middle of a payload with a byte pending
        dst_ready = '0;
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h01);
        @(negedge clk);
        check("t7_pending", 32'(dst_valid), 32'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("t7_rst_valid", 32'(dst_valid), 32'd0);
        check("t7_rst_data", {23'b0, dst_last, dst_data}, 32'd0);
        check("t7_rst_status", {28'b0, frame_ok, frame_err, err_code}, 32'd0);
        exp_q.delete();
        st_q.delete();
        last_err = 2'd0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        dst_ready = '1;
        pay_buf[0] = 8'h5A;
        d0 = n_deliv;
        send_frame(8'h01, 1, 8'hA4, 2'd0);
        wait_done(100);
        check("t7_after_reset", {23'b0, last_flag, last_data}, {23'b0, 1'b1, 8'h5A});
        check("t7_count", 32'(n_deliv - d0), 32'd1);

        repeat (4) @(posedge clk);
        check("queues_empty", 32'(exp_q.size() + st_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
